// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave in front of a 1W/1R SRAM macro: zero-wait word access,
// byte/half writes merged through the read port, 1-cycle RAW stall, 2-cycle ERROR.
// Ports: AHB-Lite slave (HCLK, HRESET, HSEL, HADDR, HTRANS, HWRITE, HSIZE,
//   HWDATA, HREADY -> HREADYOUT, HRESP, HRDATA); SRAM write port (sram_csb0,
//   sram_addr0, sram_din0) and read port (sram_csb1, sram_addr1, sram_dout1).
module ahb_sram_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_HAZ  = 3'd3;
  localparam logic [2:0] S_ERR1 = 3'd4;
  localparam logic [2:0] S_ERR2 = 3'd5;

  logic [2:0]            state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [3:0]            mask_q, mask_d;
  logic                  sub_q, sub_d;

  logic                  req, valid, illegal, a_sub, a_rd, hazard;
  logic [ADDR_WIDTH-1:0] a_idx;
  logic [3:0]            a_mask;
  logic                  unused_bits;

  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  // req ignores HREADY so the stall decision does not loop through it
  assign req     = HSEL & HTRANS[1];
  assign valid   = req & HREADY;
  assign illegal = (HSIZE > 3'd2)
                 | ((HSIZE == 3'd1) & HADDR[0])
                 | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
  assign a_idx   = HADDR[ADDR_WIDTH+1:2];
  assign a_sub   = (HSIZE != 3'd2);
  assign a_rd    = req & ~illegal & (~HWRITE | a_sub);
  assign hazard  = ~HRESET & (state_q == S_WR) & a_rd & (a_idx == idx_q);

  always_comb begin
    a_mask = 4'b1111;
    unique case (1'b1)
      (HSIZE == 3'd0): a_mask = 4'b0001 << HADDR[1:0];
      (HSIZE == 3'd1): a_mask = HADDR[1] ? 4'b1100 : 4'b0011;
      default:         a_mask = 4'b1111;
    endcase
  end

  always_comb begin
    state_d = S_IDLE;
    wr_d    = wr_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    sub_d   = sub_q;
    if (hazard || valid) begin
      wr_d   = HWRITE;
      idx_d  = a_idx;
      mask_d = a_mask;
      sub_d  = a_sub;
    end
    unique case (1'b1)
      hazard:              state_d = S_HAZ;
      (state_q == S_ERR1): state_d = S_ERR2;
      valid:               state_d = illegal ? S_ERR1
                                   : HWRITE  ? S_WR : S_RD;
      default:             state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      mask_q  <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      sub_q   <= sub_d;
    end
  end

  assign HREADYOUT = HRESET | ~((state_q == S_ERR1) | hazard);
  assign HRESP     = ~HRESET & ((state_q == S_ERR1) | (state_q == S_ERR2));
  assign HRDATA    = (~HRESET & (state_q == S_RD)) ? sram_dout1 : '0;

  assign sram_csb0  = HRESET | (state_q != S_WR);
  assign sram_addr0 = idx_q;

  // unmasked lanes keep the word fetched during the address phase
  for (genvar n = 0; n < 4; n++) begin : g_lane
    assign sram_din0[8*n +: 8] = mask_q[n] ? HWDATA[8*n +: 8]
                                           : sram_dout1[8*n +: 8];
  end

  always_comb begin
    sram_csb1  = 1'b1;
    sram_addr1 = a_idx;
    if (!HRESET) begin
      if (state_q == S_HAZ) begin
        // re-issue the read that was blocked by the write
        sram_csb1  = wr_q & ~sub_q;
        sram_addr1 = idx_q;
      end else if (valid && a_rd && !hazard) begin
        sram_csb1 = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed bench for ahb_sram_ctrl with a behavioural 1W/1R SRAM model.
// HREADY is looped back from HREADYOUT (single-slave bus).
module tb_ahb_sram_ctrl;
  localparam int AW = 8;
  localparam logic [1:0] NS  = 2'b10;
  localparam logic [1:0] SEQ = 2'b11;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic          sram_csb0;
  logic [AW-1:0] sram_addr0;
  logic [31:0]   sram_din0;
  logic          sram_csb1;
  logic [AW-1:0] sram_addr1;
  logic [31:0]   sram_dout1;

  logic [31:0] mem [2**AW];
  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int wr0;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  always @(posedge HCLK) begin
    if (!sram_csb0) mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    if (!sram_csb0) wr_cnt <= wr_cnt + 1;
  end

  ahb_sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .sram_csb0(sram_csb0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_csb1(sram_csb1),
    .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr(logic [1:0] tr, logic wr, logic [2:0] sz,
                      logic [31:0] a);
    HSEL = 1'b1;
    HTRANS = tr;
    HWRITE = wr;
    HSIZE = sz;
    HADDR = a;
    #1;
  endtask

  task automatic idle();
    HSEL = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE = 3'd2;
    HADDR = 32'h0;
    #1;
  endtask

  initial begin
    HRESET = 1'b1;
    HWDATA = 32'h0;
    idle();
    tick();
    addr(NS, 1'b0, 3'd2, 32'h10);
    chk("rst_csb1", 32'(sram_csb1), 32'd1);
    chk("rst_csb0", 32'(sram_csb0), 32'd1);
    chk("rst_rdy", 32'(HREADYOUT), 32'd1);
    tick();
    HRESET = 1'b0;
    idle();
    chk("rst_rdy2", 32'(HREADYOUT), 32'd1);
    chk("rst_resp", 32'(HRESP), 32'd0);
    chk("rst_rdata", HRDATA, 32'h0);

    // word write then read of the same word: one stall cycle
    tick();
    wr0 = wr_cnt;
    addr(NS, 1'b1, 3'd2, 32'h10);
    chk("t1_wr_csb1", 32'(sram_csb1), 32'd1);
    tick();
    HWDATA = 32'hDEADBEEF;
    addr(NS, 1'b0, 3'd2, 32'h10);
    chk("t1_haz_rdy", 32'(HREADYOUT), 32'd0);
    chk("t1_haz_csb0", 32'(sram_csb0), 32'd0);
    chk("t1_haz_csb1", 32'(sram_csb1), 32'd1);
    chk("t1_din0", sram_din0, 32'hDEADBEEF);
    tick();
    addr(NS, 1'b0, 3'd2, 32'h10);
    chk("t1_hz2_rdy", 32'(HREADYOUT), 32'd1);
    chk("t1_hz2_csb0", 32'(sram_csb0), 32'd1);
    chk("t1_hz2_csb1", 32'(sram_csb1), 32'd0);
    chk("t1_hz2_addr1", 32'(sram_addr1), 32'h4);
    tick();
    idle();
    chk("t1_rdata", HRDATA, 32'hDEADBEEF);
    chk("t1_nwr", 32'(wr_cnt - wr0), 32'd1);

    // byte write merge
    tick();
    addr(NS, 1'b1, 3'd2, 32'h20);
    tick();
    HWDATA = 32'h11223344;
    idle();
    tick();
    addr(NS, 1'b1, 3'd0, 32'h21);
    chk("t2_csb1", 32'(sram_csb1), 32'd0);
    chk("t2_addr1", 32'(sram_addr1), 32'h8);
    tick();
    HWDATA = 32'h0000AA00;
    idle();
    chk("t2_rdy", 32'(HREADYOUT), 32'd1);
    chk("t2_csb0", 32'(sram_csb0), 32'd0);
    chk("t2_din0", sram_din0, 32'h1122AA44);
    tick();
    addr(NS, 1'b0, 3'd2, 32'h20);
    tick();
    idle();
    chk("t2_rdata", HRDATA, 32'h1122AA44);

    // halfword write right behind a word write to the same word
    tick();
    addr(NS, 1'b1, 3'd2, 32'h30);
    tick();
    HWDATA = 32'h0;
    addr(NS, 1'b1, 3'd1, 32'h32);
    chk("t3_haz_rdy", 32'(HREADYOUT), 32'd0);
    tick();
    addr(NS, 1'b1, 3'd1, 32'h32);
    chk("t3_hz2_csb1", 32'(sram_csb1), 32'd0);
    chk("t3_hz2_rdy", 32'(HREADYOUT), 32'd1);
    tick();
    HWDATA = 32'hBEEF0000;
    idle();
    chk("t3_din0", sram_din0, 32'hBEEF0000);
    tick();
    addr(NS, 1'b0, 3'd2, 32'h30);
    tick();
    idle();
    chk("t3_rdata", HRDATA, 32'hBEEF0000);

    // misaligned halfword: ERROR, no memory access
    tick();
    wr0 = wr_cnt;
    addr(NS, 1'b1, 3'd1, 32'h31);
    chk("t3e_csb1", 32'(sram_csb1), 32'd1);
    tick();
    HWDATA = 32'hFFFFFFFF;
    idle();
    chk("t3e1_rdy", 32'(HREADYOUT), 32'd0);
    chk("t3e1_resp", 32'(HRESP), 32'd1);
    chk("t3e1_csb0", 32'(sram_csb0), 32'd1);
    tick();
    chk("t3e2_rdy", 32'(HREADYOUT), 32'd1);
    chk("t3e2_resp", 32'(HRESP), 32'd1);
    chk("t3e2_csb0", 32'(sram_csb0), 32'd1);
    tick();
    addr(NS, 1'b0, 3'd2, 32'h30);
    chk("t3e3_resp", 32'(HRESP), 32'd0);
    tick();
    idle();
    chk("t3e_rdata", HRDATA, 32'hBEEF0000);
    chk("t3e_nwr", 32'(wr_cnt - wr0), 32'd0);

    // back-to-back writes and SEQ reads without bubbles
    tick();
    addr(NS, 1'b1, 3'd2, 32'h40);
    tick();
    HWDATA = 32'h40404040;
    addr(NS, 1'b1, 3'd2, 32'h44);
    chk("t4_ww_rdy", 32'(HREADYOUT), 32'd1);
    tick();
    HWDATA = 32'h44444444;
    addr(NS, 1'b0, 3'd2, 32'h40);
    chk("t4_wr_rdy", 32'(HREADYOUT), 32'd1);
    tick();
    addr(SEQ, 1'b0, 3'd2, 32'h44);
    chk("t4_r0", HRDATA, 32'h40404040);
    chk("t4_r0_rdy", 32'(HREADYOUT), 32'd1);
    tick();
    addr(SEQ, 1'b0, 3'd2, 32'h40);
    chk("t4_r1", HRDATA, 32'h44444444);
    chk("t4_r1_rdy", 32'(HREADYOUT), 32'd1);
    tick();
    idle();
    chk("t4_r2", HRDATA, 32'h40404040);
    chk("t4_r2_rdy", 32'(HREADYOUT), 32'd1);

    // reset during a write data phase drops the write
    tick();
    addr(NS, 1'b1, 3'd2, 32'h50);
    tick();
    HWDATA = 32'h55AA55AA;
    idle();
    tick();
    addr(NS, 1'b1, 3'd2, 32'h50);
    tick();
    HWDATA = 32'h12345678;
    HRESET = 1'b1;
    idle();
    chk("t5_csb0", 32'(sram_csb0), 32'd1);
    tick();
    HRESET = 1'b0;
    idle();
    chk("t5_rdy", 32'(HREADYOUT), 32'd1);
    chk("t5_resp", 32'(HRESP), 32'd0);
    chk("t5_rdata0", HRDATA, 32'h0);
    tick();
    addr(NS, 1'b0, 3'd2, 32'h50);
    tick();
    idle();
    chk("t5_rdata", HRDATA, 32'h55AA55AA);

    // HSIZE=3 read
    tick();
    addr(NS, 1'b0, 3'd3, 32'h60);
    chk("t6_csb1", 32'(sram_csb1), 32'd1);
    tick();
    idle();
    chk("t6e1_rdy", 32'(HREADYOUT), 32'd0);
    chk("t6e1_resp", 32'(HRESP), 32'd1);
    chk("t6e1_csb1", 32'(sram_csb1), 32'd1);
    tick();
    chk("t6e2_rdy", 32'(HREADYOUT), 32'd1);
    chk("t6e2_resp", 32'(HRESP), 32'd1);
    tick();
    chk("t6_done_resp", 32'(HRESP), 32'd0);
    chk("t6_done_rdy", 32'(HREADYOUT), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
